// File: rtl/digit_display_mux.sv
// Two-digit key history time-multiplexed onto one seven_segment decoder,
// with blanking dead time between digit slots to suppress ghosting.
module digit_display_mux #(
    parameter int REFRESH_DIV = 20000,
    parameter int DEAD_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_key_valid,
    input  logic [3:0] new_key,
    input  logic       clear,
    output logic [4:0] s,
    output logic [1:0] anode,
    output logic [1:0] digit_count
);
    localparam int MAXN = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXN);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {SHOW_R, DEAD_RL, SHOW_L, DEAD_LR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    right_d, left_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SHOW_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        anode   = 2'b11;
        s       = 5'b1_0000;
        case (state_q)
            SHOW_R: begin
                anode = 2'b10;
                s     = {digit_count == 2'd0, right_d};
                if (cnt_q == SHOW_LAST) begin
                    state_d = DEAD_RL;
                    cnt_d   = '0;
                end
            end
            DEAD_RL: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = SHOW_L;
                    cnt_d   = '0;
                end
            end
            SHOW_L: begin
                anode = 2'b01;
                s     = {digit_count < 2'd2, left_d};
                if (cnt_q == SHOW_LAST) begin
                    state_d = DEAD_LR;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = SHOW_R;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Clear wins over the old history, but a coincident key still lands as the first digit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            right_d     <= '0;
            left_d      <= '0;
            digit_count <= '0;
        end else if (clear) begin
            left_d      <= '0;
            right_d     <= new_key_valid ? new_key : 4'h0;
            digit_count <= new_key_valid ? 2'd1 : 2'd0;
        end else if (new_key_valid) begin
            left_d      <= right_d;
            right_d     <= new_key;
            digit_count <= (digit_count == 2'd2) ? 2'd2 : digit_count + 2'd1;
        end
    end
endmodule
